// File: rtl/button_event_pkg.sv
// Shared types and sizing helpers for the button event generator.
package button_event_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    LONG     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam int BTN_L = 0;
  localparam int BTN_M = 1;
  localparam int BTN_R = 2;

  // Width that holds every value from 0 up to and including max_val.
  function automatic int cnt_width(input longint unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button input path: 2-FF synchronizer followed by a stable-count debouncer.
module btn_debounce
  import button_event_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int DW = cnt_width(DEBOUNCE_CYC);

  logic [1:0]    sync_q;
  logic [DW-1:0] cnt_q;
  logic          level_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // Any cycle where the synced level agrees with the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (sync_q[1] == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
      cnt_q   <= '0;
      level_q <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + DW'(1);
    end
  end

  assign level = level_q;

endmodule

// File: rtl/button_event_gen.sv
// Debounces the L/M/R buttons and turns their holds into short, long and repeat pulses.
module button_event_gen
  import button_event_pkg::*;
#(
  parameter int              NBTN         = 3,
  parameter int              DEBOUNCE_CYC = 500_000,
  parameter int              SHORT_CYC    = 2_500_000,
  parameter int              LONG_CYC     = 100_000_000,
  parameter int              REPEAT_CYC   = 25_000_000,
  parameter logic [NBTN-1:0] REPEAT_EN    = 3'b101
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] held,
  output logic [NBTN-1:0] short_evt,
  output logic [NBTN-1:0] long_evt,
  output logic [NBTN-1:0] repeat_evt,
  output logic            busy
);

  localparam int HW = cnt_width(LONG_CYC);
  localparam int RW = cnt_width(REPEAT_CYC);
  localparam int OW = idx_width(NBTN);

  logic [NBTN-1:0] held_lvl;

  for (genvar g = 0; g < NBTN; g++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_raw[g]),
      .level(held_lvl[g])
    );
  end

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
  logic [NBTN-1:0] short_d, long_d, repeat_d;
  logic [NBTN-1:0] owner_mask;
  logic [NBTN-1:0] others;
  logic            owner_held;

  assign owner_mask = NBTN'(1) << owner_q;
  assign others     = held_lvl & ~owner_mask;
  assign owner_held = |(held_lvl & owner_mask);

  // A second button always wins over release or timing, so chords never emit.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    short_d    = '0;
    long_d     = '0;
    repeat_d   = '0;
    case (state_q)
      IDLE: begin
        if (held_lvl != '0) begin
          if ($onehot(held_lvl)) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
            for (int i = 0; i < NBTN; i++) begin
              if (held_lvl[i]) owner_d = OW'(i);
            end
          end else begin
            state_d = WAIT_REL;
          end
        end
      end
      HOLD: begin
        if (hold_cnt_q != HW'(LONG_CYC)) hold_cnt_d = hold_cnt_q + HW'(1);
        if (others != '0) begin
          state_d = WAIT_REL;
        end else if (!owner_held) begin
          if (hold_cnt_q >= HW'(SHORT_CYC)) short_d = owner_mask;
          state_d = IDLE;
        end else if (hold_cnt_q == HW'(LONG_CYC - 1)) begin
          long_d    = owner_mask;
          rep_cnt_d = '0;
          state_d   = LONG;
        end
      end
      LONG: begin
        if (others != '0) begin
          state_d = WAIT_REL;
        end else if (!owner_held) begin
          state_d = IDLE;
        end else if ((|(REPEAT_EN & owner_mask)) && (rep_cnt_q == RW'(REPEAT_CYC - 1))) begin
          repeat_d  = owner_mask;
          rep_cnt_d = '0;
        end else if (rep_cnt_q != RW'(REPEAT_CYC)) begin
          rep_cnt_d = rep_cnt_q + RW'(1);
        end
      end
      WAIT_REL: begin
        if (held_lvl == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      short_evt  <= '0;
      long_evt   <= '0;
      repeat_evt <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      short_evt  <= short_d;
      long_evt   <= long_d;
      repeat_evt <= repeat_d;
    end
  end

  assign held = held_lvl;
  assign busy = (state_q != IDLE);

endmodule
